// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmitter among NUM_REQ valid/ready byte requesters, with message locking.
// Define UART_ARB_FIXED_PRI_EN for fixed priority (index 0 highest) instead of round-robin.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned GAP_CYCLES   = 0,
   parameter int unsigned ACK_TIMEOUT  = 1024,
   parameter int unsigned LOCK_TIMEOUT = 65535
) (
   input  logic                   hw_clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic [2:0]             grant_id,
   output logic                   locked,
   output logic                   err_ack,
   output logic                   err_lock
);

   localparam int unsigned IDX_W = 3;
   localparam int unsigned SUM_W = IDX_W + 1;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
   } state_t;

   state_t             state, state_d;
   logic [IDX_W-1:0]   ptr, ptr_d, grant_d, nxt_ptr, win_idx;
   logic               win_vld;
   logic               locked_d, tx_start_d, err_ack_d, err_lock_d;
   logic [7:0]         tx_data_d;
   logic [NUM_REQ-1:0] req_ready_d;
   logic [CNT_W-1:0]   lock_cnt, lock_cnt_d, ack_cnt, ack_cnt_d, gap_cnt, gap_cnt_d;
   logic               gnt_valid, gnt_last;
   logic [7:0]         gnt_data;

   // Inputs of the currently granted requester
   always_comb begin
      gnt_valid = 1'b0;
      gnt_last  = 1'b0;
      gnt_data  = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == IDX_W'(i)) begin
            gnt_valid = req_valid[i];
            gnt_last  = req_last[i];
            gnt_data  = req_data[8*i +: 8];
         end
      end
   end

   assign nxt_ptr = (grant_id == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0) : grant_id + IDX_W'(1);

`ifdef UART_ARB_FIXED_PRI_EN
   // Lowest index wins; descending scan leaves the lowest set bit last
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(i);
         end
      end
   end
`else
   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [SUM_W-1:0]     sum;

   // Rotate so the pointer lands at bit 0, take the first set bit, then rotate back
   always_comb begin
      win_vld = 1'b0;
      sum     = '0;
      dbl     = {req_valid, req_valid} >> ptr;
      rot     = dbl[NUM_REQ-1:0];
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            win_vld = 1'b1;
            sum     = SUM_W'(ptr) + SUM_W'(i);
         end
      end
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      win_idx = sum[IDX_W-1:0];
   end
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      ptr_d       = ptr;
      grant_d     = grant_id;
      locked_d    = locked;
      tx_data_d   = tx_data;
      tx_start_d  = 1'b0;
      req_ready_d = '0;
      err_ack_d   = 1'b0;
      err_lock_d  = 1'b0;
      lock_cnt_d  = lock_cnt;
      ack_cnt_d   = ack_cnt;
      gap_cnt_d   = gap_cnt;
      case (state)
         S_IDLE: begin
            if (locked) begin
               if (gnt_valid) begin
                  state_d     = S_LOAD;
                  req_ready_d = NUM_REQ'(1) << grant_id;
               end else if (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  locked_d   = 1'b0;
                  err_lock_d = 1'b1;
                  ptr_d      = nxt_ptr;
                  lock_cnt_d = '0;
               end else begin
                  lock_cnt_d = lock_cnt + CNT_W'(1);
               end
            end else if (win_vld) begin
               grant_d     = win_idx;
               state_d     = S_LOAD;
               req_ready_d = NUM_REQ'(1) << win_idx;
            end
         end
         S_LOAD: begin
            // A requester that withdrew before ready gets no transfer
            if (gnt_valid) begin
               tx_data_d  = gnt_data;
               locked_d   = ~gnt_last;
               lock_cnt_d = '0;
               tx_start_d = 1'b1;
               state_d    = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            ack_cnt_d = '0;
            state_d   = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
               err_ack_d = 1'b1;
               locked_d  = 1'b0;
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end else begin
               ack_cnt_d = ack_cnt + CNT_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end
         end
         S_GAP: begin
            if (32'(gap_cnt) + 32'd1 >= 32'(GAP_CYCLES)) begin
               state_d = S_IDLE;
               if (!locked) ptr_d = nxt_ptr;
            end else begin
               gap_cnt_d = gap_cnt + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge hw_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ptr       <= '0;
         grant_id  <= '0;
         locked    <= 1'b0;
         tx_data   <= 8'h00;
         tx_start  <= 1'b0;
         req_ready <= '0;
         err_ack   <= 1'b0;
         err_lock  <= 1'b0;
         lock_cnt  <= '0;
         ack_cnt   <= '0;
         gap_cnt   <= '0;
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         grant_id  <= grant_d;
         locked    <= locked_d;
         tx_data   <= tx_data_d;
         tx_start  <= tx_start_d;
         req_ready <= req_ready_d;
         err_ack   <= err_ack_d;
         err_lock  <= err_lock_d;
         lock_cnt  <= lock_cnt_d;
         ack_cnt   <= ack_cnt_d;
         gap_cnt   <= gap_cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for arbitration/locking, hand sequences for timeouts and reset.
module tb_uart_tx_arbiter;

   localparam int unsigned NUM_REQ = 4;

   logic                 hw_clk = 1'b0;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_busy = 1'b0;
   logic [2:0]           grant_id;
   logic                 locked, err_ack, err_lock;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .GAP_CYCLES(0), .ACK_TIMEOUT(16), .LOCK_TIMEOUT(20)
   ) dut (
      .hw_clk(hw_clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked), .err_ack(err_ack),
      .err_lock(err_lock)
   );

   always #5 hw_clk = ~hw_clk;

   // Transmitter model: busy for busy_len cycles starting the cycle after tx_start
   int   busy_len  = 10;
   int   busy_left = 0;
   logic tx_en     = 1'b1;
   always @(posedge hw_clk) begin
      if (busy_left > 0) begin
         busy_left <= busy_left - 1;
         tx_busy   <= (busy_left > 1);
      end else if (tx_start && tx_en) begin
         busy_left <= busy_len;
         tx_busy   <= 1'b1;
      end
   end

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  last;
      int          exp_gnt;
      logic [7:0]  exp_data;
      logic        lock_pre;
      logic        lock_post;
   } vec_t;

   vec_t tbl [12];
   int   n_chk = 0, n_fail = 0;
   int   cyc = 0, overlap = 0, ready_cnt = 0, start_cnt = 0, early = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge hw_clk);
      #1;
      cyc++;
      if (tx_start && (|req_ready)) overlap++;
      if ((|req_ready) && !$onehot(req_ready)) overlap++;
      if (|req_ready) ready_cnt++;
      if (tx_start) start_cnt++;
   endtask

   task automatic apply(input vec_t v);
      req_valid = v.valid;
      req_data  = v.data;
      req_last  = v.last;
   endtask

   task automatic wait_ready(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (|req_ready) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   // Waits for the grant of v, checks LOAD and START cycles; sc = cycle tx_start is seen
   task automatic xfer(input vec_t v, input string tag, output int sc);
      logic ok;
      sc = -1;
      wait_ready(ok);
      if (!ok) begin
         check({tag, "_ready_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, "_ready"}, 32'(req_ready), 32'd1 << v.exp_gnt);
      check({tag, "_gid"}, 32'(grant_id), 32'(v.exp_gnt));
      check({tag, "_lock_load"}, 32'(locked), 32'(v.lock_pre));
      tick();
      check({tag, "_start"}, 32'(tx_start), 32'd1);
      check({tag, "_data"}, 32'(tx_data), 32'(v.exp_data));
      check({tag, "_lock_post"}, 32'(locked), 32'(v.lock_post));
      sc = cyc;
   endtask

   task automatic quiet();
      repeat (busy_len + 8) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_start"}, 32'(tx_start), 32'd0);
      check({tag, "_txdata"}, 32'(tx_data), 32'd0);
      check({tag, "_gid"}, 32'(grant_id), 32'd0);
      check({tag, "_locked"}, 32'(locked), 32'd0);
      check({tag, "_err_ack"}, 32'(err_ack), 32'd0);
      check({tag, "_err_lock"}, 32'(err_lock), 32'd0);
   endtask

   initial begin
      int   s1, s2, ec, rc0, st0;
      vec_t v;

      // Round-robin with all four requesters continuously valid
      tbl[0]  = '{4'hF, 32'hA3A2A1A0, 4'hF, 0, 8'hA0, 1'b0, 1'b0};
      tbl[1]  = '{4'hF, 32'hA3A2A1B0, 4'hF, 1, 8'hA1, 1'b0, 1'b0};
      tbl[2]  = '{4'hF, 32'hA3A2B1B0, 4'hF, 2, 8'hA2, 1'b0, 1'b0};
      tbl[3]  = '{4'hF, 32'hA3B2B1B0, 4'hF, 3, 8'hA3, 1'b0, 1'b0};
      tbl[4]  = '{4'hF, 32'hB3B2B1B0, 4'hF, 0, 8'hB0, 1'b0, 1'b0};
      tbl[5]  = '{4'hF, 32'hB3B2B1B0, 4'hF, 1, 8'hB1, 1'b0, 1'b0};
      tbl[6]  = '{4'hF, 32'hB3B2B1B0, 4'hF, 2, 8'hB2, 1'b0, 1'b0};
      tbl[7]  = '{4'hF, 32'hB3B2B1B0, 4'hF, 3, 8'hB3, 1'b0, 1'b0};
      // Requester 2 three-byte message while requester 0 waits
      tbl[8]  = '{4'b0100, 32'h00C00000, 4'b0000, 2, 8'hC0, 1'b0, 1'b1};
      tbl[9]  = '{4'b0101, 32'h00C100D0, 4'b0001, 2, 8'hC1, 1'b1, 1'b1};
      tbl[10] = '{4'b0101, 32'h00C200D0, 4'b0101, 2, 8'hC2, 1'b1, 1'b0};
      tbl[11] = '{4'b0001, 32'h000000D0, 4'b0001, 0, 8'hD0, 1'b0, 1'b0};

      rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
      tick(); tick();
      check_reset_outputs("rst");
      @(negedge hw_clk) rst_n = 1'b1;
      tick();

      for (int k = 0; k < 8; k++) begin
         apply(tbl[k]);
         xfer(tbl[k], $sformatf("rr%0d", k), s1);
      end
      req_valid = '0;
      quiet();

      // Single requester, two back-to-back single-byte messages
      rc0 = ready_cnt;
      v = '{4'b0010, 32'h00004400, 4'b0010, 1, 8'h44, 1'b0, 1'b0};
      apply(v);
      xfer(v, "single1", s1);
      req_data = 32'h00004500;
      tick();
      check("single_start_width", 32'(tx_start), 32'd0);
      repeat (3) tick();
      check("single_data_held", 32'(tx_data), 32'h44);
      v = '{4'b0010, 32'h00004500, 4'b0010, 1, 8'h45, 1'b0, 1'b0};
      xfer(v, "single2", s2);
      req_valid = '0;
      check("single_spacing", 32'(s2 - s1), 32'(busy_len + 5));
      check("single_ready_cnt", 32'(ready_cnt - rc0), 32'd2);
      quiet();

      for (int k = 8; k < 12; k++) begin
         apply(tbl[k]);
         xfer(tbl[k], $sformatf("lock%0d", k - 8), s1);
      end
      req_valid = '0;
      quiet();

      // Lock timeout: requester 3 opens a message then goes silent
      v = '{4'b1000, 32'hE0000000, 4'b0000, 3, 8'hE0, 1'b0, 1'b1};
      apply(v);
      xfer(v, "lto", s1);
      req_valid = 4'b0001; req_data = 32'h000000F0; req_last = 4'b0001;
      early = 0; ec = -1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (|req_ready) early++;
         if (err_lock) begin
            ec = cyc;
            break;
         end
      end
      if (ec < 0) check("lto_err_timeout", 32'd0, 32'd1);
      else begin
         check("lto_err_cycle", 32'(ec - s1), 32'(busy_len + 23));
         check("lto_locked", 32'(locked), 32'd0);
         check("lto_no_early_grant", 32'(early), 32'd0);
         tick();
         check("lto_err_width", 32'(err_lock), 32'd0);
         check("lto_grant0", 32'(req_ready), 32'd1);
         check("lto_gid0", 32'(grant_id), 32'd0);
         tick();
         check("lto_data0", 32'(tx_data), 32'hF0);
      end
      req_valid = '0;
      quiet();

      // Ack timeout: transmitter never raises busy
      tx_en = 1'b0;
      v = '{4'b0010, 32'h00005500, 4'b0000, 1, 8'h55, 1'b0, 1'b1};
      apply(v);
      xfer(v, "ato", s1);
      req_valid = 4'b0100; req_data = 32'h00660000; req_last = 4'b0100;
      ec = -1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (err_ack) begin
            ec = cyc;
            break;
         end
      end
      tx_en = 1'b1;
      if (ec < 0) check("ato_err_timeout", 32'd0, 32'd1);
      else begin
         check("ato_err_cycle", 32'(ec - s1), 32'd17);
         check("ato_locked", 32'(locked), 32'd0);
         tick();
         check("ato_err_width", 32'(err_ack), 32'd0);
         check("ato_idle_ready", 32'(req_ready), 32'd0);
         tick();
         check("ato_next_grant", 32'(req_ready), 32'b0100);
         tick();
         check("ato_next_data", 32'(tx_data), 32'h66);
      end
      req_valid = '0;
      quiet();

      // Reset while the transmitter is busy
      v = '{4'b0001, 32'h00000077, 4'b0000, 0, 8'h77, 1'b0, 1'b1};
      apply(v);
      xfer(v, "mrst", s1);
      req_valid = '0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mrst");
      @(negedge hw_clk) rst_n = 1'b1;
      st0 = start_cnt;
      repeat (20) tick();
      check("mrst_no_start", 32'(start_cnt - st0), 32'd0);
      check("mrst_locked", 32'(locked), 32'd0);

      check("ready_start_exclusive", 32'(overlap), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
